// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule types and constants.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WIN      = 16;
  localparam int unsigned MAX_BASE = 48;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/sigma_0.sv
// SHA-256 small sigma_0: ROTR7 ^ ROTR18 ^ SHR3.
module sigma_0
  import sha256_pkg::*;
(
  input  word_t xg_0,
  output word_t sig_0
);

  assign sig_0 = {xg_0[6:0],  xg_0[31:7]}
               ^ {xg_0[17:0], xg_0[31:18]}
               ^ (xg_0 >> 3);

endmodule

// File: rtl/sigma_1.sv
// SHA-256 small sigma_1: ROTR17 ^ ROTR19 ^ SHR10.
module sigma_1
  import sha256_pkg::*;
(
  input  word_t xg_1,
  output word_t sig_1
);

  assign sig_1 = {xg_1[16:0], xg_1[31:17]}
               ^ {xg_1[18:0], xg_1[31:19]}
               ^ (xg_1 >> 10);

endmodule

// File: rtl/sha256_sched_rewind.sv
// Runs the SHA-256 message schedule backwards: loads W[j..j+15] and emits
// W[j-1] down to W[0], one word per output handshake.
module sha256_sched_rewind
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  base_idx,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic        busy
);

  state_t     state_q, state_d;
  word_t      win_q [WIN];
  word_t      win_d [WIN];
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] idx_q, idx_d;

  word_t      s0, s1, nw;
  logic [5:0] base_sat;

  sigma_0 u_sigma_0 (
    .xg_0  (win_q[0]),
    .sig_0 (s0)
  );

  sigma_1 u_sigma_1 (
    .xg_1  (win_q[13]),
    .sig_1 (s1)
  );

  // Window holds W[i+1..i+16]; solving the forward recurrence for W[i].
  assign nw       = win_q[15] - s1 - win_q[8] - s0;
  assign base_sat = (base_idx > 6'(MAX_BASE)) ? 6'(MAX_BASE) : base_idx;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_word   = '0;
    busy       = 1'b0;

    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          idx_d    = base_sat;
          win_d[0] = load_word;
          cnt_d    = 4'd1;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          win_d[cnt_q] = load_word;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = (idx_q == 6'd0) ? IDLE : RUN;
          end
        end
      end

      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (idx_q == 6'd1);
        out_word  = nw;
        if (out_ready) begin
          win_d[0] = nw;
          for (int unsigned k = 1; k < WIN; k++) begin
            win_d[k] = win_q[k-1];
          end
          idx_d = idx_q - 6'd1;
          if (idx_q == 6'd1) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int unsigned k = 0; k < WIN; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: doc/sha256_sched_rewind.md
Name: sha256_sched_rewind

Overview:
- Runs the SHA-256 message-schedule recurrence backwards.
- Takes a 16-word window W[j..j+15] and emits W[j-1], W[j-2], …, W[0], one word per accepted handshake.
- Used by the TRNG post-processing and self-test path to recover original message-block words from a captured schedule window.
- Reuses the existing sigma_0 module plus a new sigma_1.

Parameters:
- WORD_W, 32, schedule word width; fixed at 32, SHA-256 only.
- WIN, 16, window depth in words; fixed at 16.
- MAX_BASE, 48, largest legal window start index j.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- base_idx  in  6  window start index j; sampled on the first load beat.
- load_valid  in  1  load word is present.
- load_ready  out  1  block accepts a load word.
- load_word  in  32  window word; sent oldest first, W[j] first and W[j+15] last.
- out_valid  out  1  recovered word is available.
- out_ready  in  1  consumer accepts the recovered word.
- out_word  out  32  recovered word W[i].
- out_last  out  1  marks the word W[0].
- busy  out  1  high in LOAD or RUN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; window cleared to 0; load count=0; index register=0.
  - load_ready=1, out_valid=0, out_last=0, busy=0.
  - out_word reads 0 while out_valid=0.
- Window registers w[0..15] hold W[i+1..i+16].
  - Combinational next word: nw = w[15] − σ1(w[13]) − w[8] − σ0(w[0]), mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - out_word = nw.
- IDLE:
  - load_ready=1.
  - On load_valid: capture min(base_idx, MAX_BASE) into idx; write load_word into w[0]; count=1; go to LOAD.
- LOAD:
  - load_ready=1; each accepted beat writes w[count] and increments count.
  - On the 16th beat (count==15 accepted):
    - if idx==0, go to IDLE; no output is produced.
    - otherwise go to RUN; out_valid rises the next cycle.
  - The first out_valid appears exactly one cycle after the final load beat.
- RUN:
  - load_ready=0; out_valid=1; out_last = (idx==1).
  - On out_valid && out_ready:
    - shift w'[0]=nw and w'[k]=w[k−1] for k=1..15; idx−=1.
    - if idx was 1, go to IDLE and deassert out_valid in the same edge.
  - Holding rule: while out_ready=0, out_word and out_last hold stable (window frozen).
  - Throughput: one word per cycle when out_ready is held high.
- Boundaries:
  - base_idx>48 saturates to 48.
  - base_idx changes after the first beat are ignored.
  - load_valid in RUN is ignored (no back-pressure violation; load_ready=0).
  - rst_n low mid-LOAD or mid-RUN aborts immediately to reset values; partial windows are discarded.
  - Subtraction wraps modulo 2^32; no saturation, no carry out.

Decomposition:
- Shared package sha256_pkg:
  - word_t (32-bit);
  - state enum {IDLE, LOAD, RUN};
  - constants WIN=16 and MAX_BASE=48.
- Sub-modules:
  - new sigma_1, combinational, mirroring the sigma_0 interface (xg_1 → sig_1);
  - existing sigma_0, instantiated on w[0].
- The FSM, window and subtractor chain live in the top module.

Test Plan:
- Reset mid-RUN: load any window with base_idx=5, accept 2 outputs, pulse rst_n low → out_valid=0 and busy=0 asynchronously; the next load starts clean.
- Single step, "abc" block:
  - stimulus: base_idx=1; load fourteen 0x00000000, then 0x00000018, then 0x61626380 (W1..W16).
  - response: one cycle later out_valid=1, out_word=0x61626380, out_last=1; after handshake → IDLE.
- Two steps:
  - stimulus: base_idx=2; load thirteen zeros, 0x00000018, 0x61626380, 0x000F0000 (W2..W17).
  - response: out_word=0x00000000 with out_last=0, then 0x61626380 with out_last=1.
- Back-pressure: repeat the two-step case with out_ready=0 for 5 cycles → out_word=0x00000000 stable, out_valid=1 held, no index advance.
- Round trip:
  - forward-generate W0..W63 from a random block in the bench, load W48..W63 with base_idx=48 and out_ready=1.
  - response: 48 consecutive words equal W47..W0; out_last only on W0.
- Edge indices:
  - base_idx=0 → full load, no out_valid, return to IDLE.
  - base_idx=63 → behaves as 48, 48 outputs.
